phy_link_ctrl: RTL and testbench
================================

PHY_LINK_CTRL -- requirements
Module: phy_link_ctrl

Interface
REQ-001 Parameter SYNC_WORD, default 32'hBCBCBCBC: training pattern sent and expected during link training.
REQ-002 Parameter SYNC_COUNT, default 4: consecutive matching received words that declare lock; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 255: TRAIN cycles without lock before a retry; legal range 1..255.
REQ-004 Port clk_32f  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports req0 / req1  input  1  requester N has a word to send.
REQ-007 Ports data0 / data1  input  32  requester N payload, valid while reqN=1.
REQ-008 Ports gnt0 / gnt1  output  1  combinational grant; requester N's word is taken this cycle.
REQ-009 Port retrain  input  1  request to drop the link and re-enter training.
REQ-010 Port rx_data  input  32  word recovered by the PHY receiver.
REQ-011 Port rx_valid  input  1  rx_data qualifier from the PHY receiver.
REQ-012 Port phy_data  output  32  word driven to the PHY transmitter data input.
REQ-013 Port phy_valid  output  1  qualifier driven to the PHY transmitter valid input.
REQ-014 Port sincronizar_bus  output  1  receiver-synchronisation enable driven to the PHY.
REQ-015 Port link_up  output  1  high only in state ACTIVE.
REQ-016 Port train_fail  output  1  one-cycle pulse on each training timeout.

Function
REQ-017 FSM states SHALL be TRAIN and ACTIVE; all outputs SHALL be registered except gnt0/gnt1.
REQ-018 TRAIN outputs: phy_data=SYNC_WORD, phy_valid=1, sincronizar_bus=1, link_up=0, gnt0=gnt1=0.
REQ-019 TRAIN match counter: +1 on rx_valid=1 with rx_data==SYNC_WORD; cleared on rx_valid=1 with any other value; held on rx_valid=0.
REQ-020 When the match counter reaches SYNC_COUNT, the FSM SHALL go to ACTIVE on the next edge, and the match and timeout counters SHALL clear.
REQ-021 TRAIN timeout counter: +1 every TRAIN cycle.
REQ-022 When the timeout counter reaches TIMEOUT without lock, the block SHALL do all of the following:
  - pulse train_fail for exactly 1 cycle;
  - clear both counters;
  - remain in TRAIN.
REQ-023 Lock and timeout on the same edge: lock SHALL win and train_fail SHALL stay 0.
REQ-024 ACTIVE outputs: sincronizar_bus=0, link_up=1.
REQ-025 ACTIVE arbitration is round-robin with a 1-bit last-grant pointer:
  - only one request: that requester is granted;
  - both request: the port not granted last is granted;
  - never more than one grant per cycle.
REQ-026 A grant SHALL update the pointer to the granted port; no grant leaves the pointer unchanged.
REQ-027 Latency: the granted dataN SHALL appear on phy_data with phy_valid=1 exactly 1 cycle after the grant.
REQ-028 Cycles with no grant SHALL produce phy_valid=0 and phy_data=32'h0 on the next cycle.
REQ-029 retrain=1 in ACTIVE SHALL force gnt0=gnt1=0 that cycle and move to TRAIN on the next edge with counters cleared.
REQ-030 retrain in TRAIN has no effect; rx_valid and rx_data are ignored in ACTIVE.

Reset
REQ-031 While reset=1, asynchronously and without waiting for a clock edge:
  - state=TRAIN, both counters=0, pointer=1 (so port 0 wins the first contention);
  - phy_data=32'h0, phy_valid=0, sincronizar_bus=0, link_up=0, train_fail=0.
REQ-032 The first edge after reset deasserts SHALL drive the TRAIN outputs of REQ-018.
REQ-033 Reset asserted mid-operation in any state SHALL abort immediately to the REQ-031 values; an in-flight word is discarded.

Verification
REQ-034 Lock: after reset, four consecutive rx_valid=1 words of 32'hBCBCBCBC -> link_up=1 and sincronizar_bus=0 on the next cycle; train_fail never pulses.
REQ-035 Match broken: sync, sync, sync, then 32'h12345678, then 4 sync -> lock only after the final 4 syncs; a gap with rx_valid=0 does not clear the count.
REQ-036 Timeout: rx_valid=0 held for 600 cycles -> train_fail pulses on cycles 255 and 510 after entering TRAIN, each 1 cycle wide; link_up stays 0.
REQ-037 Arbitration: in ACTIVE with req0=req1=1 held, data0=32'hA, data1=32'hB:
  - grants alternate gnt0, gnt1, gnt0, ...;
  - phy_data follows 1 cycle later as A, B, A, ... with phy_valid=1.
REQ-038 Retrain: retrain=1 in ACTIVE while req0=1 -> gnt0=0 that cycle; next cycle state=TRAIN, phy_data=SYNC_WORD, sincronizar_bus=1, link_up=0.
REQ-039 Async reset: reset pulsed between clock edges while in ACTIVE -> all outputs reach their reset values before the next edge; a new training sequence starts afterwards.

Source files
------------

// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl -- link training and two-port round-robin transmit arbiter.
//
// In TRAIN the block streams SYNC_WORD to the PHY and watches the receiver
// for SYNC_COUNT consecutive matching words. A lock moves it to ACTIVE.
// Going TIMEOUT cycles without a lock pulses train_fail and restarts the
// attempt. In ACTIVE two requesters share the transmitter round-robin.
//
// Ports:
//   clk_32f          single clock, rising edge
//   reset            asynchronous, active-high
//   req0/req1        requester N has a word to send
//   data0/data1      requester N payload
//   gnt0/gnt1        combinational grant, the word is taken this cycle
//   retrain          drop the link and re-enter training (ACTIVE only)
//   rx_data/rx_valid word recovered by the PHY receiver
//   phy_data/valid   registered word/qualifier to the PHY transmitter
//   sincronizar_bus  receiver-synchronisation enable (registered)
//   link_up          high in ACTIVE (registered)
//   train_fail       one-cycle pulse per training timeout (registered)
module phy_link_ctrl #(
    parameter logic [31:0] SYNC_WORD  = 32'hBCBCBCBC,
    parameter int          SYNC_COUNT = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic        retrain,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] phy_data,
    output logic        phy_valid,
    output logic        sincronizar_bus,
    output logic        link_up,
    output logic        train_fail
);

    typedef enum logic {TRAIN = 1'b0, ACTIVE = 1'b1} state_t;

    // Terminal values are compared one count early so that the edge which
    // takes a counter to its limit is the edge that acts on it.
    localparam logic [7:0] MATCH_LAST = 8'(SYNC_COUNT - 1);
    localparam logic [7:0] TOUT_LAST  = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] match_cnt;
    logic [7:0] tout_cnt;
    logic       last_gnt;   // 1: port 1 was granted last, so port 0 wins a tie

    logic sync_hit;
    logic lock;
    logic tout;

    assign sync_hit = rx_valid && (rx_data == SYNC_WORD);
    assign lock     = sync_hit && (match_cnt == MATCH_LAST);
    assign tout     = (tout_cnt == TOUT_LAST);

    // Grants are combinational so the requester can pop its word this cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ACTIVE && !retrain) begin
            if (req0 && req1) begin
                gnt0 = last_gnt;
                gnt1 = !last_gnt;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state           <= TRAIN;
            match_cnt       <= 8'd0;
            tout_cnt        <= 8'd0;
            last_gnt        <= 1'b1;
            phy_data        <= 32'h0;
            phy_valid       <= 1'b0;
            sincronizar_bus <= 1'b0;
            link_up         <= 1'b0;
            train_fail      <= 1'b0;
        end else begin
            train_fail <= 1'b0;
            case (state)
                TRAIN: begin
                    phy_data        <= SYNC_WORD;
                    phy_valid       <= 1'b1;
                    sincronizar_bus <= 1'b1;
                    link_up         <= 1'b0;
                    // Lock takes priority over a coincident timeout.
                    if (lock) begin
                        state           <= ACTIVE;
                        match_cnt       <= 8'd0;
                        tout_cnt        <= 8'd0;
                        phy_data        <= 32'h0;
                        phy_valid       <= 1'b0;
                        sincronizar_bus <= 1'b0;
                        link_up         <= 1'b1;
                    end else if (tout) begin
                        train_fail <= 1'b1;
                        match_cnt  <= 8'd0;
                        tout_cnt   <= 8'd0;
                    end else begin
                        tout_cnt <= tout_cnt + 8'd1;
                        if (rx_valid)
                            match_cnt <= sync_hit ? match_cnt + 8'd1 : 8'd0;
                    end
                end
                ACTIVE: begin
                    if (retrain) begin
                        state           <= TRAIN;
                        match_cnt       <= 8'd0;
                        tout_cnt        <= 8'd0;
                        phy_data        <= SYNC_WORD;
                        phy_valid       <= 1'b1;
                        sincronizar_bus <= 1'b1;
                        link_up         <= 1'b0;
                    end else begin
                        sincronizar_bus <= 1'b0;
                        link_up         <= 1'b1;
                        if (gnt0) begin
                            phy_data  <= data0;
                            phy_valid <= 1'b1;
                            last_gnt  <= 1'b0;
                        end else if (gnt1) begin
                            phy_data  <= data1;
                            phy_valid <= 1'b1;
                            last_gnt  <= 1'b1;
                        end else begin
                            phy_data  <= 32'h0;
                            phy_valid <= 1'b0;
                        end
                    end
                end
                default: state <= TRAIN;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_link_ctrl.sv
// Bench for phy_link_ctrl: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model of the link rules.
module tb_phy_link_ctrl;

    localparam logic [31:0] SYNC = 32'hBCBCBCBC;
    localparam int SYNC_COUNT = 4;
    localparam int TIMEOUT    = 255;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, retrain = 1'b0, rx_valid = 1'b0;
    logic [31:0] data0 = 32'h0, data1 = 32'h0, rx_data = 32'h0;
    logic        gnt0, gnt1, phy_valid, sincronizar_bus, link_up, train_fail;
    logic [31:0] phy_data;

    phy_link_ctrl #(.SYNC_WORD(SYNC), .SYNC_COUNT(SYNC_COUNT), .TIMEOUT(TIMEOUT)) dut (
        .clk_32f(clk_32f), .reset(reset),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .retrain(retrain),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .phy_data(phy_data), .phy_valid(phy_valid),
        .sincronizar_bus(sincronizar_bus), .link_up(link_up), .train_fail(train_fail)
    );

    always #5 clk_32f = ~clk_32f;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // {phy_valid, sincronizar_bus, link_up, train_fail, phy_data}
    function automatic logic [35:0] pack(input logic pv, input logic sb, input logic lu,
                                         input logic tf, input logic [31:0] pd);
        return {pv, sb, lu, tf, pd};
    endfunction

    function automatic logic [35:0] outs();
        return {phy_valid, sincronizar_bus, link_up, train_fail, phy_data};
    endfunction

    task automatic idle_inputs();
        req0 = 0; req1 = 0; retrain = 0; rx_valid = 0; rx_data = 0;
    endtask

    // Reset held across an edge, released mid-cycle. Caller is then at +3
    // after an edge and the next edge is the first one out of reset.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(posedge clk_32f); #3;
        reset = 0;
    endtask

    task automatic tick();
        @(posedge clk_32f); #1;
    endtask

    task automatic send_sync(input int n);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1; rx_data = SYNC;
            tick();
        end
        rx_valid = 0;
    endtask

    typedef struct {
        logic r0, r1, rt, rv;
        logic [31:0] rd;
        logic g0, g1, lu, pv;
        logic [31:0] pd;
    } vec_t;

    vec_t vt[13];

    // reference model state
    bit          m_active;
    int          m_match, m_tout, m_last;
    logic        eg0, eg1;
    logic [35:0] e_out;

    int          fails_seen[$];
    bit          link_seen;

    initial begin
        // ---------------- reset values, asynchronous ----------------
        #1;
        chk("reset_outs", 64'(outs()), 64'(pack(0, 0, 0, 0, 32'h0)));
        @(posedge clk_32f); #1;
        chk("reset_held_outs", 64'(outs()), 64'(pack(0, 0, 0, 0, 32'h0)));
        #2 reset = 0;
        tick();
        chk("first_edge_train", 64'(outs()), 64'(pack(1, 1, 0, 0, SYNC)));

        // ---------------- table-driven: lock then arbitrate ----------------
        vt[0]  = '{0, 0, 0, 1, SYNC,         0, 0, 0, 1, SYNC};
        vt[1]  = '{0, 0, 0, 1, SYNC,         0, 0, 0, 1, SYNC};
        vt[2]  = '{0, 0, 0, 0, 32'h0,        0, 0, 0, 1, SYNC}; // gap holds count
        vt[3]  = '{0, 0, 0, 1, SYNC,         0, 0, 0, 1, SYNC};
        vt[4]  = '{1, 1, 0, 1, SYNC,         0, 0, 1, 0, 32'h0}; // no grant in TRAIN
        vt[5]  = '{1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 32'hA};
        vt[6]  = '{1, 1, 0, 1, 32'h12345678, 0, 1, 1, 1, 32'hB}; // rx ignored
        vt[7]  = '{1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 32'hA};
        vt[8]  = '{0, 1, 0, 0, 32'h0,        0, 1, 1, 1, 32'hB};
        vt[9]  = '{0, 1, 0, 0, 32'h0,        0, 1, 1, 1, 32'hB};
        vt[10] = '{1, 1, 0, 0, 32'h0,        1, 0, 1, 1, 32'hA};
        vt[11] = '{0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 32'h0};
        vt[12] = '{1, 0, 1, 0, 32'h0,        0, 0, 0, 1, SYNC}; // retrain
        data0 = 32'hA; data1 = 32'hB;
        for (int i = 0; i < 13; i++) begin
            req0 = vt[i].r0; req1 = vt[i].r1; retrain = vt[i].rt;
            rx_valid = vt[i].rv; rx_data = vt[i].rd;
            #1;
            chk($sformatf("vec%0d_gnt", i), 64'({gnt0, gnt1}), 64'({vt[i].g0, vt[i].g1}));
            tick();
            chk($sformatf("vec%0d_outs", i), 64'(outs()),
                64'(pack(vt[i].pv, !vt[i].lu, vt[i].lu, 1'b0, vt[i].pd)));
        end

        // ---------------- broken match ----------------
        do_reset();
        begin
            logic [31:0] seq[9];
            logic        vld[9];
            seq = '{SYNC, SYNC, SYNC, 32'h12345678, 32'h0, SYNC, SYNC, SYNC, SYNC};
            vld = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
            for (int i = 0; i < 9; i++) begin
                rx_valid = vld[i]; rx_data = seq[i];
                tick();
                chk($sformatf("broken%0d_link", i), 64'(link_up), 64'(i == 8));
            end
        end

        // ---------------- lock and timeout on the same edge ----------------
        do_reset();
        for (int e = 1; e <= TIMEOUT; e++) begin
            rx_valid = (e > TIMEOUT - SYNC_COUNT); rx_data = SYNC;
            tick();
            if (e == TIMEOUT - 1) chk("coinc_prelink", 64'(link_up), 64'(0));
        end
        chk("coinc_outs", 64'(outs()), 64'(pack(0, 0, 1, 0, 32'h0)));

        // ---------------- timeout pulses ----------------
        do_reset();
        fails_seen.delete();
        link_seen = 0;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (train_fail) fails_seen.push_back(c);
            if (link_up) link_seen = 1;
        end
        chk("tout_npulses", 64'(fails_seen.size()), 64'(2));
        if (fails_seen.size() == 2) begin
            chk("tout_pulse1", 64'(fails_seen[0]), 64'(TIMEOUT));
            chk("tout_pulse2", 64'(fails_seen[1]), 64'(2 * TIMEOUT));
        end
        chk("tout_link", 64'(link_seen), 64'(0));

        // ---------------- asynchronous reset in ACTIVE ----------------
        do_reset();
        send_sync(SYNC_COUNT);
        req0 = 1; data0 = 32'hCAFE0001;
        tick();
        chk("areset_pre", 64'(outs()), 64'(pack(1, 0, 1, 0, 32'hCAFE0001)));
        #2 reset = 1;
        #1;
        chk("areset_outs", 64'(outs()), 64'(pack(0, 0, 0, 0, 32'h0)));
        chk("areset_gnt", 64'({gnt0, gnt1}), 64'(0));
        #2 reset = 0; req0 = 0;
        tick();
        chk("areset_train", 64'(outs()), 64'(pack(1, 1, 0, 0, SYNC)));
        send_sync(SYNC_COUNT);
        chk("areset_relock", 64'(link_up), 64'(1));

        // ---------------- randomized vs. reference model ----------------
        do_reset();
        m_active = 0; m_match = 0; m_tout = 0; m_last = 1;
        for (int c = 0; c < 3000; c++) begin
            req0     = ($urandom_range(0, 99) < 60);
            req1     = ($urandom_range(0, 99) < 60);
            data0    = $urandom;
            data1    = $urandom;
            retrain  = ($urandom_range(0, 99) < 3);
            rx_valid = ($urandom_range(0, 99) < 70);
            rx_data  = ($urandom_range(0, 99) < 85) ? SYNC : $urandom;
            #1;
            eg0 = 0; eg1 = 0;
            if (m_active && !retrain) begin
                if (req0 && req1) begin
                    if (m_last == 1) eg0 = 1; else eg1 = 1;
                end else begin
                    eg0 = req0; eg1 = req1;
                end
            end
            chk("rand_gnt", 64'({gnt0, gnt1}), 64'({eg0, eg1}));

            if (!m_active) begin
                m_tout = m_tout + 1;
                if (rx_valid) m_match = (rx_data == SYNC) ? m_match + 1 : 0;
                if (m_match == SYNC_COUNT) begin
                    m_active = 1; m_match = 0; m_tout = 0;
                    e_out = pack(0, 0, 1, 0, 32'h0);
                end else if (m_tout == TIMEOUT) begin
                    m_match = 0; m_tout = 0;
                    e_out = pack(1, 1, 0, 1, SYNC);
                end else begin
                    e_out = pack(1, 1, 0, 0, SYNC);
                end
            end else if (retrain) begin
                m_active = 0; m_match = 0; m_tout = 0;
                e_out = pack(1, 1, 0, 0, SYNC);
            end else if (eg0) begin
                m_last = 0;
                e_out = pack(1, 0, 1, 0, data0);
            end else if (eg1) begin
                m_last = 1;
                e_out = pack(1, 0, 1, 0, data1);
            end else begin
                e_out = pack(0, 0, 1, 0, 32'h0);
            end
            tick();
            chk("rand_outs", 64'(outs()), 64'(e_out));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
